cpu_sequencer: RTL

Multi-cycle control unit for the assembled CPU. It owns the program counter, fetches instructions from the instruction RAM, latches them into an instruction register that drives the decode fields of the register bank, ALU and memory control, and evaluates the condition field against a held flag register. It sequences the writeback and data-RAM strobes for each instruction, so a CPU run needs no bench-driven address stepping.

---
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: PC, instruction register, condition/flag evaluation and strobe sequencing.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a Step input and a PAUSE state at instruction boundaries.
module cpu_sequencer #(
  parameter int          PC_WIDTH  = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                Step,
`endif
  input  logic [31:0]         Out_i,
  input  logic [3:0]          New_Flag,
  output logic                Enable_i,
  output logic                RW_ram_i,
  output logic [PC_WIDTH-1:0] Address_in_i,
  output logic [31:0]         IR,
  output logic [3:0]          Flag,
  output logic                Enable,
  output logic                RW_ram,
  output logic                reg_we,
  output logic                Halted,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE = 3'd7
`endif
  } state_t;

  localparam logic [3:0] OP_LDR = 4'hD;
  localparam logic [3:0] OP_STR = 4'hE;
  localparam logic [3:0] OP_B   = 4'hF;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [3:0]          flag_q, flag_d;
  logic                cond_pass;
  state_t              boundary_st;

  wire [3:0] cond   = ir_q[31:28];
  wire [3:0] opcode = ir_q[27:24];
  wire       f_n    = flag_q[3];
  wire       f_z    = flag_q[2];
  wire       f_c    = flag_q[1];
  wire       f_v    = flag_q[0];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = !f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = !f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = !f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = !f_v;
      4'h8: cond_pass = f_c && !f_z;
      4'h9: cond_pass = !f_c || f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = !f_z && (f_n == f_v);
      4'hD: cond_pass = f_z || (f_n != f_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Run is only consulted here, so an instruction in flight always completes.
  always_comb begin
`ifdef SEQ_SINGLE_STEP_EN
    boundary_st = Run ? S_PAUSE : S_IDLE;
`else
    boundary_st = Run ? S_FETCH : S_IDLE;
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = Out_i;
        pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (ir_q == HALT_WORD)  state_d = S_HALT;
        else if (!cond_pass)    state_d = boundary_st;
        else                    state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q[23]) flag_d = New_Flag;
        case (opcode)
          OP_LDR, OP_STR: state_d = S_MEM;
          OP_B: begin
            pc_d    = ir_q[PC_WIDTH-1:0];
            state_d = boundary_st;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM:  state_d = (opcode == OP_LDR) ? S_WB : boundary_st;
      S_WB:   state_d = boundary_st;
      S_HALT: state_d = S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (!Run)      state_d = S_IDLE;
        else if (Step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
    end
  end

  // Strobes are gated by Reset so a reset edge during MEM/WB never writes.
  assign Enable_i     = Reset && (state_q == S_FETCH);
  assign RW_ram_i     = Reset && (state_q == S_FETCH);
  assign Enable       = Reset && (state_q == S_MEM);
  assign RW_ram       = Reset && (state_q == S_MEM) && (opcode == OP_LDR);
  assign reg_we       = Reset && (state_q == S_WB);
  assign Halted       = (state_q == S_HALT);
  assign Address_in_i = pc_q;
  assign IR           = ir_q;
  assign Flag         = flag_q;
  assign state        = state_q;

endmodule
